// File: rtl/router_input_arbiter_if.sv
// Bundle of the requester, router and status signals around router_input_arbiter.
// The master modport is the arbiter's view; the slave modport is the
// sources/router side.
interface router_input_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   grant;
    logic [7:0]           dut_inp;
    logic                 inp_valid;
    logic                 busy;
    logic [2:0]           active_id;
    logic [15:0]          pkt_count;
    logic                 err_proto;
    logic                 err_len;

    modport master (
        input  req, req_valid, req_data, busy,
        output grant, dut_inp, inp_valid, active_id, pkt_count, err_proto, err_len
    );

    modport slave (
        output req, req_valid, req_data, busy,
        input  grant, dut_inp, inp_valid, active_id, pkt_count, err_proto, err_len
    );
endinterface

// File: rtl/router_input_arbiter.sv
// Round-robin arbiter that shares the router's single byte-stream input among
// NUM_REQ packet sources. One source at a time is granted. Its bytes are
// forwarded with one register of latency. Over-long packets are cut and
// drained. Every packet is followed by a forced idle gap.
module router_input_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int MAX_PKT_LEN   = 64,
    parameter int GAP_CYCLES    = 2,
    parameter int START_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    router_input_arbiter_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);
    localparam int TO_W  = $clog2(START_TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    logic [2:0]         r_state;
    logic [2:0]         r_rr_ptr;
    logic [NUM_REQ-1:0] r_grant;
    logic [2:0]         r_active_id;
    logic [7:0]         r_dut_inp;
    logic               r_inp_valid;
    logic [15:0]        r_pkt_count;
    logic               r_err_proto;
    logic               r_err_len;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [TO_W-1:0]    r_to_cnt;

    logic [NUM_REQ-1:0] w_viol;
    logic               w_any_viol;
    logic               w_sel_valid;
    logic               w_sel_req;
    logic [7:0]         w_sel_data;
    logic               w_found;
    logic [2:0]         w_winner;
    logic [2:0]         w_next_ptr;
    logic [NUM_REQ-1:0] w_winner_oh;
    logic               w_timeout;

    // A strobe from any source that does not hold the grant is a protocol
    // violation. Its data is never forwarded.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
            assign w_viol[gi]      = bus.req_valid[gi] & ~r_grant[gi];
            assign w_winner_oh[gi] = (w_winner == 3'(gi));
        end
    endgenerate

    assign w_any_viol = |w_viol;

    // Steer the granted source's request, strobe and byte onto common wires.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_req   = 1'b0;
        w_sel_data  = 8'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_active_id == 3'(k)) begin
                w_sel_valid = bus.req_valid[k];
                w_sel_req   = bus.req[k];
                w_sel_data  = bus.req_data[8*k +: 8];
            end
        end
    end

    // The winner is the first request at or above the RR pointer. If there is
    // none, the search wraps to the lowest set request.
    always_comb begin
        w_found  = 1'b0;
        w_winner = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && bus.req[k] && (3'(k) >= r_rr_ptr)) begin
                w_found  = 1'b1;
                w_winner = 3'(k);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && bus.req[k]) begin
                w_found  = 1'b1;
                w_winner = 3'(k);
            end
        end
        w_next_ptr = (w_winner == 3'(NUM_REQ - 1)) ? 3'd0 : w_winner + 3'd1;
    end

    // The start timeout fires on the START_TIMEOUT-th cycle in GRANT. It fires
    // only when there is no byte and the request is still held.
    assign w_timeout = (r_state == S_GRANT) && !w_sel_valid && w_sel_req &&
                       (r_to_cnt == TO_W'(START_TIMEOUT - 1));

    // Arbitration FSM, byte forwarding path, counters and error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= 3'd0;
            r_grant     <= '0;
            r_active_id <= 3'd0;
            r_dut_inp   <= 8'd0;
            r_inp_valid <= 1'b0;
            r_pkt_count <= 16'd0;
            r_err_proto <= 1'b0;
            r_err_len   <= 1'b0;
            r_byte_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_to_cnt    <= '0;
        end else begin
            // A stray strobe and a timeout in the same cycle merge into one pulse.
            r_err_proto <= w_any_viol | w_timeout;
            r_err_len   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // busy is looked at only here. Held requests are simply
                    // served later.
                    if (!bus.busy && w_found) begin
                        r_grant     <= w_winner_oh;
                        r_active_id <= w_winner;
                        r_rr_ptr    <= w_next_ptr;
                        r_to_cnt    <= '0;
                        r_state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_sel_valid) begin
                        r_dut_inp   <= w_sel_data;
                        r_inp_valid <= 1'b1;
                        r_byte_cnt  <= CNT_W'(1);
                        r_state     <= S_XFER;
                    end else if (!w_sel_req || w_timeout) begin
                        r_grant <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_XFER: begin
                    if (w_sel_valid) begin
                        if (r_byte_cnt == CNT_W'(MAX_PKT_LEN)) begin
                            // Cut the packet. The grant stays until the source
                            // stops so that its tail is swallowed.
                            r_inp_valid <= 1'b0;
                            r_err_len   <= 1'b1;
                            r_state     <= S_DRAIN;
                        end else begin
                            r_dut_inp  <= w_sel_data;
                            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_inp_valid <= 1'b0;
                        r_grant     <= '0;
                        r_pkt_count <= r_pkt_count + 16'd1;
                        r_gap_cnt   <= GAP_W'(GAP_CYCLES);
                        r_state     <= S_GAP;
                    end
                end
                S_DRAIN: begin
                    if (!w_sel_valid) begin
                        r_grant   <= '0;
                        r_gap_cnt <= GAP_W'(GAP_CYCLES);
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt <= GAP_W'(1)) begin
                        r_gap_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    r_grant     <= '0;
                    r_inp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant     = r_grant;
    assign bus.active_id = r_active_id;
    assign bus.dut_inp   = r_dut_inp;
    assign bus.inp_valid = r_inp_valid;
    assign bus.pkt_count = r_pkt_count;
    assign bus.err_proto = r_err_proto;
    assign bus.err_len   = r_err_len;
endmodule
